seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised Mealy serial-pattern detector; next generation of the fixed 4-bit detectors.
//  Pattern, length, don't-care mask and overlap mode are run-time inputs, so no per-pattern module is needed.
//  Example: the "x000" detector is pattern=0000, mask=0111, pat_len=4.
//  Sits between a serial bit source (qualified by x_valid) and downstream counters/flags.
// PARAMETERS
//  MAX_LEN  8  longest supported pattern, in bits (>=2)
//  LW       4  width of pat_len; must hold MAX_LEN
//  CNT_W    8  match_count width (used only with SEQDET_MATCH_CNT_EN)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low
//  clear        in   1        synchronous flush of history/counter, active-high
//  x_valid      in   1        x is a valid sample this cycle
//  x            in   1        serial input bit
//  pattern      in   MAX_LEN  pattern[0]=last bit expected, pattern[pat_len-1]=first
//  mask         in   MAX_LEN  1=compare bit, 0=don't care (same indexing as pattern)
//  pat_len      in   LW       active pattern length; valid range 1..MAX_LEN
//  overlap      in   1        1=overlapping matches allowed, 0=restart after a match
//  y            out  1        Mealy match flag, combinational, same cycle as the last bit
//  y_reg        out  1        y registered (1-cycle latency)
//  match_count  out  CNT_W    saturating count of matches (only with SEQDET_MATCH_CNT_EN)
// BEHAVIOUR
//  - State: hist[MAX_LEN-1:0] (newest bit at hist[0]); fcnt = valid bits held, 0..MAX_LEN, saturating.
//  - FSM view of fcnt: EMPTY (fcnt=0), FILL (fcnt<pat_len-1), ARMED (fcnt>=pat_len-1).
//  - win = {hist[MAX_LEN-2:0], x}.
//  - hit = x_valid & !clear & len_ok & (fcnt+1 >= pat_len)
//          & ((win ^ pattern) & mask & lenmask) == 0.
//    len_ok = 1<=pat_len<=MAX_LEN; lenmask = ones in bits [pat_len-1:0].
//  - y = hit, purely combinational from inputs and state; no clock delay.
//  - Posedge with clear=1: hist=0, fcnt=0, y_reg=0, match_count=0. clear overrides x_valid.
//  - Posedge with x_valid=1: hist<=win[MAX_LEN-1:0].
//      fcnt <= (hit & !overlap) ? 0 : min(fcnt+1, MAX_LEN).
//  - Posedge with x_valid=0: hist and fcnt hold; y=0 that cycle.
//  - y_reg <= hit on every posedge.
//  - Invalid pat_len (0 or >MAX_LEN): y never asserts; history still shifts.
//  - pattern/mask/pat_len/overlap are sampled combinationally every cycle.
//    Changing them mid-stream is legal: matching uses the new config against the existing history.
//    Software issues clear when a fresh start is required.
//  - mask=0 in all active bits: match on every valid bit once fcnt+1>=pat_len.
//  - Reset (async, low): hist=0, fcnt=0, y_reg=0, match_count=0, all immediately.
//    y=0 while reset is low. Reset mid-pattern discards partial matches.
// CONFIGURATION
//  SEQDET_MATCH_CNT_EN defined:
//    match_count += 1 on each posedge with hit=1; saturates at 2^CNT_W-1; zeroed by clear and by reset.
//  SEQDET_MATCH_CNT_EN undefined:
//    no counter logic; match_count is tied to 0. Port list is unchanged.
// TESTING (MAX_LEN=8, LW=4, CNT_W=8, x_valid=1 unless stated)
//  1 pattern=0000 mask=0111 len=4 ov=1; x=1,0,1,1,0,0,0,1,0,0,0,1,0,0,0,0
//    -> y=1 on bits 7,11,15,16 only; match_count=4.
//  2 pattern=1101 mask=1111 len=4; x=1,1,0,1,1,0,1
//    -> ov=1: y on bits 4 and 7. ov=0: y on bit 4 only.
//  3 pattern=1101 len=4; x=1,1,0, then 3 cycles x_valid=0 with x=1, then x=1
//    -> y=0 during the stall; y=1 on the final bit; y_reg=1 one cycle later.
//  4 pattern=1101; x=1,1,0, reset low between edges, release, then x=1
//    -> outputs 0 immediately at reset; no match until 1,1,0,1 is re-sent.
//  5 len=0 and len=9 with any stream -> y never 1.
//    len=8, pattern=10110011, exact stream -> y=1 on bit 8.
//  6 CNT_W=2, SEQDET_MATCH_CNT_EN: 5 matches -> match_count=3; clear -> match_count=0.
//    Same test without the macro -> match_count stays 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Run-time configurable Mealy serial-pattern detector (pattern, mask, length, overlap).
// Optional saturating match counter: define SEQDET_MATCH_CNT_EN.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LW      = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               x_valid,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [MAX_LEN-1:0] mask,
  input  logic [LW-1:0]      pat_len,
  input  logic               overlap,
  output logic               y,
  output logic               y_reg,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FW = LW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    ARMED
  } st_t;

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] lenmask;
  logic [FW-1:0]      fcnt;
  logic [FW-1:0]      fcnt_nxt;
  logic [FW-1:0]      fcnt_p1;
  logic [FW-1:0]      len_x;
  st_t                st;
  logic               len_ok;
  logic               hit;

  assign win     = {hist[MAX_LEN-2:0], x};
  assign len_x   = {1'b0, pat_len};
  assign fcnt_p1 = fcnt + FW'(1);
  assign len_ok  = (pat_len != '0) &&
                   (len_x <= FW'(MAX_LEN));

  always_comb begin
    lenmask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      lenmask[i] = FW'(i) < len_x;
  end

  // Fill level seen as a state: armed once the incoming bit completes a window
  always_comb begin
    st = EMPTY;
    if (fcnt_p1 >= len_x)
      st = ARMED;
    else if (fcnt != '0)
      st = FILL;
  end

  assign hit = x_valid & ~clear & len_ok &
               (st == ARMED) &
               ~|((win ^ pattern) & mask & lenmask);

  assign y = hit & reset;

  always_comb begin
    hist_nxt = hist;
    fcnt_nxt = fcnt;
    if (x_valid) begin
      hist_nxt = win;
      if (hit && !overlap)
        fcnt_nxt = '0;
      else if (fcnt < FW'(MAX_LEN))
        fcnt_nxt = fcnt_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist  <= '0;
      fcnt  <= '0;
      y_reg <= 1'b0;
    end else if (clear) begin
      hist  <= '0;
      fcnt  <= '0;
      y_reg <= 1'b0;
    end else begin
      hist  <= hist_nxt;
      fcnt  <= fcnt_nxt;
      y_reg <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (hit && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: vector table plus
// stall, reset, clear and counter-saturation sequences.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       x_valid;
  logic       x;
  logic [7:0] pattern;
  logic [7:0] mask;
  logic [3:0] pat_len;
  logic       overlap;
  logic       y;
  logic       y_reg;
  logic [7:0] match_count;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detector_param #(
    .MAX_LEN(8),
    .LW(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .x_valid(x_valid),
    .x(x),
    .pattern(pattern),
    .mask(mask),
    .pat_len(pat_len),
    .overlap(overlap),
    .y(y),
    .y_reg(y_reg),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pat;
    logic [7:0] msk;
    logic [3:0] len;
    logic       ov;
    string      seq;
    string      expy;
    int         cnt;
  } vec_t;

  function automatic int ecnt(input int n);
`ifdef SEQDET_MATCH_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [7:0] m,
                     input logic [3:0] l, input logic o);
    pattern = p;
    mask    = m;
    pat_len = l;
    overlap = o;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear   = 1'b1;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_yreg", int'(y_reg), 0);
  endtask

  // drive one sample, check y before the edge and y_reg after it
  task automatic step(input logic v, input logic b,
                      input logic ey, input string nm);
    @(negedge clk);
    x_valid = v;
    x       = b;
    #1;
    chk({nm, "_y"}, int'(y), int'(ey));
    @(posedge clk);
    #1;
    chk({nm, "_yreg"}, int'(y_reg), int'(ey));
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{"x000", 8'h00, 8'h07, 4'd4, 1'b1,
              "1011000100010000", "0000001000100011", 4};
    vt[1] = '{"p1101_ov", 8'h0D, 8'h0F, 4'd4, 1'b1,
              "1101101", "0001001", 2};
    vt[2] = '{"p1101_nov", 8'h0D, 8'h0F, 4'd4, 1'b0,
              "1101101", "0001000", 1};
    vt[3] = '{"len0", 8'h00, 8'h00, 4'd0, 1'b1,
              "10110", "00000", 0};
    vt[4] = '{"len9", 8'h00, 8'h00, 4'd9, 1'b1,
              "10110011", "00000000", 0};
    vt[5] = '{"len8", 8'hB3, 8'hFF, 4'd8, 1'b1,
              "10110011", "00000001", 1};
    vt[6] = '{"mask0_l3", 8'h05, 8'h00, 4'd3, 1'b1,
              "01101", "00111", 3};
    vt[7] = '{"mask0_l2_nov", 8'h00, 8'h00, 4'd2, 1'b0,
              "110100", "010101", 3};
    vt[8] = '{"len1_nov", 8'h01, 8'h01, 4'd1, 1'b0,
              "10011", "10011", 3};

    reset   = 1'b0;
    clear   = 1'b0;
    x_valid = 1'b0;
    x       = 1'b0;
    cfg(8'h0D, 8'h0F, 4'd4, 1'b1);
    #12;
    chk("rst_y", int'(y), 0);
    chk("rst_yreg", int'(y_reg), 0);
    chk("rst_cnt", int'(match_count), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[k]) begin
      cfg(vt[k].pat, vt[k].msk, vt[k].len, vt[k].ov);
      do_clear();
      for (int i = 0; i < vt[k].seq.len(); i++)
        step(1'b1, vt[k].seq[i] == "1",
             vt[k].expy[i] == "1", vt[k].name);
      #1;
      chk({vt[k].name, "_cnt"}, int'(match_count),
          ecnt(vt[k].cnt));
    end

    // stall: x_valid low holds history and blocks y
    cfg(8'h0D, 8'h0F, 4'd4, 1'b1);
    do_clear();
    step(1'b1, 1'b1, 1'b0, "stall_a");
    step(1'b1, 1'b1, 1'b0, "stall_b");
    step(1'b1, 1'b0, 1'b0, "stall_c");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, "stall_hold");
    step(1'b1, 1'b1, 1'b1, "stall_hit");

    // async reset mid-stream drops history, count and y_reg
    do_clear();
    step(1'b1, 1'b1, 1'b0, "rs_a");
    step(1'b1, 1'b1, 1'b0, "rs_b");
    step(1'b1, 1'b0, 1'b0, "rs_c");
    step(1'b1, 1'b1, 1'b1, "rs_hit");
    @(negedge clk);
    x_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rs_now_yreg", int'(y_reg), 0);
    chk("rs_now_cnt", int'(match_count), 0);
    x_valid = 1'b1;
    x       = 1'b1;
    #1;
    chk("rs_now_y", int'(y), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, "rs_after1");
    step(1'b1, 1'b0, 1'b0, "rs_after0");
    step(1'b1, 1'b1, 1'b0, "rs_after1b");
    step(1'b1, 1'b1, 1'b0, "rs_re_a");
    step(1'b1, 1'b0, 1'b0, "rs_re_b");
    step(1'b1, 1'b1, 1'b1, "rs_re_hit");

    // clear overrides a valid bit and flushes history
    do_clear();
    step(1'b1, 1'b1, 1'b0, "clr_a");
    step(1'b1, 1'b1, 1'b0, "clr_b");
    step(1'b1, 1'b0, 1'b0, "clr_c");
    @(negedge clk);
    clear   = 1'b1;
    x_valid = 1'b1;
    x       = 1'b1;
    #1;
    chk("clr_ovr_y", int'(y), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    step(1'b1, 1'b1, 1'b0, "clr_after");

    // every valid bit matches: counter must saturate
    cfg(8'h00, 8'h00, 4'd1, 1'b1);
    do_clear();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      x       = i[0];
    end
    @(negedge clk);
    x_valid = 1'b0;
    chk("sat_cnt", int'(match_count), ecnt(300));
    do_clear();
    chk("sat_clr_cnt", int'(match_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
